mem_rmw_seq: RTL and testbench

MEM_RMW_SEQ -- requirements
Module: mem_rmw_seq

---
 rtl/core_mem_pkg.sv | 24 ++
 rtl/rmw_merge.sv | 16 +
 rtl/mem_rmw_seq.sv | 142 ++++++++++++++
 tb/tb_mem_rmw_seq.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_pkg.sv
// Shared definitions for the read-modify-write store sequencer: FSM state
// encoding, byte-strobe constants and the legal-strobe decode.
package core_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WR      = 2'd3
  } state_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_FULL = 4'b1111;

  // Only naturally aligned byte, halfword (including the middle pair) and word stores.
  function automatic logic strb_legal(input logic [3:0] strb);
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: strb_legal = 1'b1;
      default:                            strb_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rmw_merge.sv
// Byte-lane merge: lanes selected by strb come from new_word, the rest from old_word.
module rmw_merge (
  input  logic [3:0]  strb,
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_rmw_seq.sv
// Store sequencer: turns partial-word stores into read-merge-write on a
// word-wide memory, with full-word bypass, read timeout and a sticky error flag.
module mem_rmw_seq
  import core_mem_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter bit FULL_BYPASS = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_ADDR,
  input  logic [3:0]  REQ_STRB,
  input  logic [31:0] REQ_DATA,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_RADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_WREN,
  output logic [31:0] MEM_WADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_WREADY,
  output logic        BUSY,
  output logic        ERR,
  input  logic        ERR_CLR,
  output logic [1:0]  DBG_STATE
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      strb_q, strb_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            err_q, err_d;
  logic            err_set;
  logic [31:0]     merged_w;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^REQ_ADDR[1:0];
  assign cnt_inc         = cnt_q + CW'(1);

  rmw_merge u_merge (
    .strb     (strb_q),
    .old_word (MEM_RDATA),
    .new_word (data_q),
    .merged   (merged_w)
  );

  // Handshakes: a request transfers on a rising edge where REQ_VALID && REQ_READY;
  // the read returns on the first edge in RD_WAIT with MEM_RVALID; the write
  // completes on the first edge in WR with MEM_WREADY, address/data held until then.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          addr_d = REQ_ADDR[31:2];
          strb_d = REQ_STRB;
          data_d = REQ_DATA;
          cnt_d  = '0;
          if (REQ_STRB != STRB_NONE) begin
            if (!strb_legal(REQ_STRB)) begin
              err_set = 1'b1;
            end else if (FULL_BYPASS && (REQ_STRB == STRB_FULL)) begin
              wdata_d = REQ_DATA;
              state_d = ST_WR;
            end else begin
              state_d = ST_RD_REQ;
            end
          end
        end
      end
      ST_RD_REQ: begin
        cnt_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // A read return in the expiry cycle still completes the store.
        if (MEM_RVALID) begin
          wdata_d = merged_w;
          state_d = ST_WR;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
      ST_WR: begin
        if (MEM_WREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_q;
    if (ERR_CLR) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign MEM_RDEN  = (state_q == ST_RD_REQ);
  assign MEM_WREN  = (state_q == ST_WR);
  assign MEM_RADDR = {addr_q, 2'b00};
  assign MEM_WADDR = {addr_q, 2'b00};
  assign MEM_WDATA = wdata_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_rmw_seq.sv
// Bench for mem_rmw_seq: a long-timeout instance drives the memory model and
// scoreboard, a TIMEOUT=4 twin on the same inputs covers read-timeout behaviour.
module tb_mem_rmw_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, ERR_CLR;
  logic [31:0] REQ_ADDR, REQ_DATA;
  logic [3:0]  REQ_STRB;
  logic        MEM_RVALID, MEM_WREADY;
  logic [31:0] MEM_RDATA;

  logic        REQ_READY, MEM_RDEN, MEM_WREN, BUSY, ERR;
  logic [31:0] MEM_RADDR, MEM_WADDR, MEM_WDATA;
  logic [1:0]  DBG_STATE;
  logic        REQ_READY_b, MEM_RDEN_b, MEM_WREN_b, BUSY_b, ERR_b;
  logic [31:0] MEM_RADDR_b, MEM_WADDR_b, MEM_WDATA_b;
  logic [1:0]  DBG_STATE_b;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  int rden_cnt = 0, wren_cyc = 0, wr_cnt = 0;

  logic        resp_en = 1'b0, rd_armed = 1'b0, wready_rand = 1'b0, wready_level = 1'b1;
  int          rd_delay = 0, rd_left = 0;
  logic [31:0] rd_word = '0;

  mem_rmw_seq #(.TIMEOUT(16), .FULL_BYPASS(1'b1)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_STRB(REQ_STRB), .REQ_DATA(REQ_DATA),
    .MEM_RDEN(MEM_RDEN), .MEM_RADDR(MEM_RADDR), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .MEM_WREN(MEM_WREN), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA), .MEM_WREADY(MEM_WREADY),
    .BUSY(BUSY), .ERR(ERR), .ERR_CLR(ERR_CLR), .DBG_STATE(DBG_STATE)
  );

  mem_rmw_seq #(.TIMEOUT(4), .FULL_BYPASS(1'b1)) dut_to (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY_b),
    .REQ_ADDR(REQ_ADDR), .REQ_STRB(REQ_STRB), .REQ_DATA(REQ_DATA),
    .MEM_RDEN(MEM_RDEN_b), .MEM_RADDR(MEM_RADDR_b), .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA),
    .MEM_WREN(MEM_WREN_b), .MEM_WADDR(MEM_WADDR_b), .MEM_WDATA(MEM_WDATA_b), .MEM_WREADY(MEM_WREADY),
    .BUSY(BUSY_b), .ERR(ERR_b), .ERR_CLR(ERR_CLR), .DBG_STATE(DBG_STATE_b)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_merge(input logic [3:0] s, input logic [31:0] old_w,
                                              input logic [31:0] new_w);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = s[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit model_legal(input logic [3:0] s);
    return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b1111};
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_responder
    logic saw_rden;
    MEM_RVALID = 1'b0;
    MEM_RDATA  = '0;
    MEM_WREADY = 1'b1;
    forever begin
      @(negedge CLK);
      saw_rden = (MEM_RDEN === 1'b1);
      @(posedge CLK);
      #2;
      MEM_RVALID = 1'b0;
      if (saw_rden && resp_en) begin
        rd_armed = 1'b1;
        rd_left  = rd_delay;
      end
      if (rd_armed) begin
        if (rd_left == 0) begin
          MEM_RVALID = 1'b1;
          MEM_RDATA  = rd_word;
          rd_armed   = 1'b0;
        end else begin
          rd_left--;
        end
      end
      MEM_WREADY = wready_rand ? 1'($urandom_range(0, 1)) : wready_level;
    end
  end

  // ---------------- write scoreboard ----------------
  initial begin : write_monitor
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      if (MEM_RDEN === 1'b1) rden_cnt++;
      if (MEM_WREN === 1'b1) wren_cyc++;
      if (MEM_WREN === 1'b1 && MEM_WREADY === 1'b1) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: got addr=%h data=%h, required no write", MEM_WADDR, MEM_WDATA);
        end else begin
          e = exp_q.pop_front();
          if ({MEM_WADDR, MEM_WDATA} !== e) begin
            failures++;
            $display("FAIL write_content: got addr=%h data=%h, required addr=%h data=%h",
                     MEM_WADDR, MEM_WDATA, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    REQ_ADDR  = a;
    REQ_STRB  = s;
    REQ_DATA  = d;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_ready(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (REQ_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_err_clr();
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    ERR_CLR = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({REQ_READY, BUSY, MEM_RDEN, MEM_WREN, ERR} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy,busy,rden,wren,err=%b, required 10000",
               {REQ_READY, BUSY, MEM_RDEN, MEM_WREN, ERR});
    end
    checks++;
    if ({MEM_RADDR, MEM_WADDR, MEM_WDATA} !== 96'd0) begin
      failures++;
      $display("FAIL reset_regs: got raddr=%h waddr=%h wdata=%h, required 0", MEM_RADDR, MEM_WADDR, MEM_WDATA);
    end
    checks++;
    if ({REQ_READY_b, BUSY_b, ERR_b} !== 3'b100) begin
      failures++;
      $display("FAIL reset_twin: got rdy,busy,err=%b, required 100", {REQ_READY_b, BUSY_b, ERR_b});
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_full_word();
    int r0, w0, c0;
    wready_level = 1'b1;
    r0 = rden_cnt; w0 = wren_cyc; c0 = wr_cnt;
    exp_q.push_back({32'h0000_0100, 32'hDEAD_BEEF});
    send_req(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    checks++;
    if ({MEM_WREN, REQ_READY, BUSY, MEM_RDEN} !== 4'b1010 || MEM_WDATA !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL full_wr_cycle: got wren,rdy,busy,rden=%b wdata=%h, required 1010 deadbeef",
               {MEM_WREN, REQ_READY, BUSY, MEM_RDEN}, MEM_WDATA);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({REQ_READY, MEM_WREN} !== 2'b10) begin
      failures++;
      $display("FAIL full_ready_back: got rdy,wren=%b, required 10", {REQ_READY, MEM_WREN});
    end
    checks++;
    if (rden_cnt != r0 || wren_cyc != w0 + 1 || wr_cnt != c0 + 1) begin
      failures++;
      $display("FAIL full_counts: got rden=%0d wren_cyc=%0d writes=%0d, required 0 1 1",
               rden_cnt - r0, wren_cyc - w0, wr_cnt - c0);
    end
  endtask

  task automatic test_partial();
    resp_en = 1'b1; rd_delay = 0; rd_word = 32'h1122_3344; wready_level = 1'b1;
    exp_q.push_back({32'h0000_0200, 32'h1122_AB44});
    send_req(32'h0000_0203, 4'b0010, 32'h0000_AB00);
    checks++;
    if (MEM_RDEN !== 1'b1 || MEM_WREN !== 1'b0 || MEM_RADDR !== 32'h0000_0200) begin
      failures++;
      $display("FAIL partial_rden: got rden=%b wren=%b raddr=%h, required 1 0 00000200",
               MEM_RDEN, MEM_WREN, MEM_RADDR);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({MEM_RDEN, MEM_WREN, BUSY} !== 3'b001) begin
      failures++;
      $display("FAIL partial_wait: got rden,wren,busy=%b, required 001", {MEM_RDEN, MEM_WREN, BUSY});
    end
    @(posedge CLK);
    #1;
    checks++;
    if (MEM_WREN !== 1'b1 || MEM_WDATA !== 32'h1122_AB44 || MEM_WADDR !== 32'h0000_0200) begin
      failures++;
      $display("FAIL partial_wr: got wren=%b wdata=%h waddr=%h, required 1 1122ab44 00000200",
               MEM_WREN, MEM_WDATA, MEM_WADDR);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (REQ_READY !== 1'b1) begin
      failures++;
      $display("FAIL partial_done: got rdy=%b, required 1", REQ_READY);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, d, w;
    int cyc;
    bit busy_ok;
    a = $urandom; d = $urandom;
    rd_word = $urandom; rd_delay = 5; resp_en = 1'b1; wready_level = 1'b0;
    w = model_merge(4'b0110, rd_word, d);
    exp_q.push_back({a & 32'hFFFF_FFFC, w});
    send_req(a, 4'b0110, d);
    cyc = 1; busy_ok = 1'b1;
    while (MEM_WREN !== 1'b1 && cyc < 40) begin
      if (BUSY !== 1'b1) busy_ok = 1'b0;
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 8) begin
      failures++;
      $display("FAIL stall_latency: got wren at cycle %0d, required 8", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (MEM_WREN !== 1'b1 || BUSY !== 1'b1 || MEM_WDATA !== w || MEM_WADDR !== (a & 32'hFFFF_FFFC)) begin
        failures++;
        $display("FAIL stall_hold%0d: got wren=%b busy=%b wdata=%h waddr=%h, required 1 1 %h %h",
                 i, MEM_WREN, BUSY, MEM_WDATA, MEM_WADDR, w, a & 32'hFFFF_FFFC);
      end
      @(posedge CLK);
      #1;
    end
    wready_level = 1'b1;
    if (BUSY !== 1'b1) busy_ok = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (!busy_ok || REQ_READY !== 1'b1) begin
      failures++;
      $display("FAIL stall_busy: got busy_ok=%0d rdy=%b, required 1 1", busy_ok, REQ_READY);
    end
    checks++;
    if ({ERR_b, REQ_READY_b, MEM_WREN_b} !== 3'b110) begin
      failures++;
      $display("FAIL twin_timeout_in_stall: got err,rdy,wren=%b, required 110", {ERR_b, REQ_READY_b, MEM_WREN_b});
    end
    pulse_err_clr();
    checks++;
    if ({ERR, ERR_b} !== 2'b00) begin
      failures++;
      $display("FAIL stall_err_clr: got err,err_b=%b, required 00", {ERR, ERR_b});
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, d, w;
    bit ok, b_quiet, b_wait_ok;
    int cyc;
    a = $urandom; d = $urandom;
    resp_en = 1'b0; wready_level = 1'b1;
    send_req(a, 4'b1100, d);
    checks++;
    if (MEM_RDEN_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_rden: got rden_b=%b, required 1", MEM_RDEN_b);
    end
    b_wait_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK);
      #1;
      if ({ERR_b, BUSY_b, MEM_WREN_b} !== 3'b010) b_wait_ok = 1'b0;
    end
    checks++;
    if (!b_wait_ok) begin
      failures++;
      $display("FAIL timeout_waiting: got early err/idle/write in 4 wait cycles, required none");
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({ERR_b, REQ_READY_b, MEM_WREN_b} !== 3'b110) begin
      failures++;
      $display("FAIL timeout_abort: got err,rdy,wren=%b, required 110", {ERR_b, REQ_READY_b, MEM_WREN_b});
    end
    // Release the long-timeout instance; the late RVALID must not disturb the idle twin.
    rd_word = $urandom;
    w = model_merge(4'b1100, rd_word, d);
    exp_q.push_back({a & 32'hFFFF_FFFC, w});
    rd_left = 0; rd_armed = 1'b1;
    b_quiet = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MEM_WREN_b !== 1'b0 || MEM_RDEN_b !== 1'b0 || REQ_READY_b !== 1'b1) b_quiet = 1'b0;
      if (REQ_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    checks++;
    if (!ok || !b_quiet || ERR_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_late_rvalid: got main_done=%0d twin_quiet=%0d err_b=%b, required 1 1 1",
               ok, b_quiet, ERR_b);
    end
    pulse_err_clr();
    checks++;
    if (ERR_b !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err_clr: got err_b=%b, required 0", ERR_b);
    end
    // Read return in the last allowed wait cycle beats expiry.
    a = $urandom; d = $urandom; rd_word = $urandom;
    rd_delay = 3; resp_en = 1'b1;
    w = model_merge(4'b0001, rd_word, d);
    exp_q.push_back({a & 32'hFFFF_FFFC, w});
    send_req(a, 4'b0001, d);
    cyc = 1;
    while (MEM_WREN_b !== 1'b1 && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (cyc != 6 || ERR_b !== 1'b0 || MEM_WDATA_b !== w || MEM_WADDR_b !== (a & 32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL timeout_race: got cycle=%0d err_b=%b wdata_b=%h waddr_b=%h, required 6 0 %h %h",
               cyc, ERR_b, MEM_WDATA_b, MEM_WADDR_b, w, a & 32'hFFFF_FFFC);
    end
    wait_ready(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_race_done: got ready=0 after 20 cycles, required 1");
    end
  endtask

  task automatic test_strb_errors();
    int r0, w0;
    wready_level = 1'b1;
    r0 = rden_cnt; w0 = wren_cyc;
    send_req($urandom, 4'b0101, $urandom);
    checks++;
    if ({ERR, REQ_READY, BUSY} !== 3'b110) begin
      failures++;
      $display("FAIL illegal_strb: got err,rdy,busy=%b, required 110", {ERR, REQ_READY, BUSY});
    end
    pulse_err_clr();
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got err=%b, required 0", ERR);
    end
    send_req($urandom, 4'b0000, $urandom);
    checks++;
    if ({ERR, REQ_READY, BUSY} !== 3'b010) begin
      failures++;
      $display("FAIL zero_strb: got err,rdy,busy=%b, required 010", {ERR, REQ_READY, BUSY});
    end
    send_req($urandom, 4'b1010, $urandom);
    ERR_CLR = 1'b1;
    send_req($urandom, 4'b0111, $urandom);
    ERR_CLR = 1'b0;
    checks++;
    if (ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_set_beats_clr: got err=%b, required 1", ERR);
    end
    pulse_err_clr();
    checks++;
    if (ERR !== 1'b0 || rden_cnt != r0 || wren_cyc != w0) begin
      failures++;
      $display("FAIL strb_no_access: got err=%b rden=%0d wren_cyc=%0d, required 0 0 0",
               ERR, rden_cnt - r0, wren_cyc - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, w;
    logic [3:0]  s;
    logic        clr, m_err;
    bit          ok, legal;
    int          r0, exp_rd;
    m_err = 1'b0;
    resp_en = 1'b1; wready_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s = 4'($urandom_range(0, 15));
      a = $urandom; d = $urandom;
      rd_word  = $urandom;
      rd_delay = $urandom_range(0, 3);
      clr      = ($urandom_range(0, 5) == 0);
      legal    = model_legal(s);
      exp_rd   = (s != 4'b0000 && legal && s != 4'b1111) ? 1 : 0;
      if (s != 4'b0000 && legal) begin
        w = (s == 4'b1111) ? d : model_merge(s, rd_word, d);
        exp_q.push_back({a & 32'hFFFF_FFFC, w});
      end
      r0 = rden_cnt;
      ERR_CLR = clr;
      send_req(a, s, d);
      ERR_CLR = 1'b0;
      m_err = (m_err & ~clr) | (s != 4'b0000 && !legal);
      wait_ready(60, ok);
      checks++;
      if (!ok || ERR !== m_err || (rden_cnt - r0) != exp_rd) begin
        failures++;
        $display("FAIL rand_%0d: strb=%b got done=%0d err=%b reads=%0d, required 1 %b %0d",
                 n, s, ok, ERR, rden_cnt - r0, m_err, exp_rd);
      end
    end
    wready_rand = 1'b0;
    wready_level = 1'b1;
    pulse_err_clr();
  endtask

  task automatic test_mid_reset();
    int c0;
    bit quiet;
    wready_level = 1'b0;
    c0 = wr_cnt;
    send_req($urandom, 4'b1111, $urandom);
    checks++;
    if (MEM_WREN !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got wren=%b, required 1", MEM_WREN);
    end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({MEM_WREN, MEM_RDEN, REQ_READY, BUSY, ERR, MEM_WREN_b} !== 6'b001000 || MEM_WDATA !== 32'd0) begin
      failures++;
      $display("FAIL midrst_async: got wren,rden,rdy,busy,err,wren_b=%b wdata=%h, required 001000 0",
               {MEM_WREN, MEM_RDEN, REQ_READY, BUSY, ERR, MEM_WREN_b}, MEM_WDATA);
    end
    wready_level = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(posedge CLK);
      #1;
      if (MEM_WREN !== 1'b0 || REQ_READY !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet || wr_cnt != c0) begin
      failures++;
      $display("FAIL midrst_after: got quiet=%0d writes=%0d, required 1 0", quiet, wr_cnt - c0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST = 1'b0; REQ_VALID = 1'b0; ERR_CLR = 1'b0;
    REQ_ADDR = '0; REQ_STRB = '0; REQ_DATA = '0;
    test_reset();
    test_full_word();
    test_partial();
    test_stall();
    test_timeout();
    test_strb_errors();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
